pipeline_ctrl: RTL and testbench

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

---
 rtl/cpu_def_pkg.sv | 28 ++
 rtl/pipeline_ctrl_forwarding.sv | 36 +++
 rtl/pipeline_ctrl.sv | 134 +++++++++++++
 tb/tb_pipeline_ctrl.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_def_pkg.sv
// Shared CPU definitions: register address width, multi-cycle unit latencies
// and the pipeline control state encoding.
package cpu_def_pkg;

  localparam int unsigned REG_ADDR_BITS = 5;
  localparam int unsigned MULT_CYCLES   = 4;
  localparam int unsigned DIV_CYCLES    = 32;
  localparam int unsigned CNT_BITS      = 5;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MDU      = 2'd1,
    MEM_WAIT = 2'd2
  } ctrl_state_e;

  // Counter preload: the issue cycle is already the first stall cycle.
  function automatic logic [CNT_BITS-1:0] mdu_load(input logic div);
    return div ? CNT_BITS'(DIV_CYCLES - 1) : CNT_BITS'(MULT_CYCLES - 1);
  endfunction

  // Register 0 is hardwired to zero and never forwarded.
  function automatic logic fwd_hit(input logic [REG_ADDR_BITS-1:0] src,
                                   input logic [REG_ADDR_BITS-1:0] dst,
                                   input logic                     we);
    return (src != '0) && (src == dst) && we;
  endfunction

endpackage

// File: rtl/pipeline_ctrl_forwarding.sv
// Bypass selection for the decode-stage branch comparator and the
// execute-stage ALU operands.
module forwarding_unit
  import cpu_def_pkg::*;
(
  input  logic [REG_ADDR_BITS-1:0] rs_d,
  input  logic [REG_ADDR_BITS-1:0] rt_d,
  input  logic [REG_ADDR_BITS-1:0] rs_e,
  input  logic [REG_ADDR_BITS-1:0] rt_e,
  input  logic [REG_ADDR_BITS-1:0] write_reg_m,
  input  logic [REG_ADDR_BITS-1:0] write_reg_w,
  input  logic                     reg_write_m,
  input  logic                     reg_write_w,
  output logic                     forward_a_d,
  output logic                     forward_b_d,
  output logic [1:0]               forward_a_e,
  output logic [1:0]               forward_b_e
);

  always_comb begin
    forward_a_d = fwd_hit(rs_d, write_reg_m, reg_write_m);
    forward_b_d = fwd_hit(rt_d, write_reg_m, reg_write_m);
  end

  // Memory stage holds the younger result, so it wins over writeback.
  always_comb begin
    forward_a_e = 2'b00;
    if (fwd_hit(rs_e, write_reg_m, reg_write_m))      forward_a_e = 2'b10;
    else if (fwd_hit(rs_e, write_reg_w, reg_write_w)) forward_a_e = 2'b01;

    forward_b_e = 2'b00;
    if (fwd_hit(rt_e, write_reg_m, reg_write_m))      forward_b_e = 2'b10;
    else if (fwd_hit(rt_e, write_reg_w, reg_write_w)) forward_b_e = 2'b01;
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline hazard control: load-use and branch interlocks, multi-cycle
// mult/div stall sequencing, data-memory wait stalls and operand forwarding.
module pipeline_ctrl
  import cpu_def_pkg::*;
(
  input  logic                     clk,
  input  logic                     clr,
  input  logic [REG_ADDR_BITS-1:0] rs_d,
  input  logic [REG_ADDR_BITS-1:0] rt_d,
  input  logic [REG_ADDR_BITS-1:0] rs_e,
  input  logic [REG_ADDR_BITS-1:0] rt_e,
  input  logic [REG_ADDR_BITS-1:0] write_reg_e,
  input  logic [REG_ADDR_BITS-1:0] write_reg_m,
  input  logic [REG_ADDR_BITS-1:0] write_reg_w,
  input  logic                     reg_write_e,
  input  logic                     reg_write_m,
  input  logic                     reg_write_w,
  input  logic                     mem_to_reg_e,
  input  logic                     mem_to_reg_m,
  input  logic                     branch_d,
  input  logic                     pc_src_d,
  input  logic                     mdu_start_e,
  input  logic                     mdu_div_e,
  input  logic                     dmem_req_m,
  input  logic                     dmem_ready,
  output logic                     forward_a_d,
  output logic                     forward_b_d,
  output logic [1:0]               forward_a_e,
  output logic [1:0]               forward_b_e,
  output logic                     stall_f,
  output logic                     stall_d,
  output logic                     stall_e,
  output logic                     stall_m,
  output logic                     stall_w,
  output logic                     flush_d,
  output logic                     flush_e,
  output logic                     flush_m,
  output logic                     mdu_busy
);

  ctrl_state_e         state, state_nxt;
  logic [CNT_BITS-1:0] cnt, cnt_nxt;
  logic                mdu_done, mdu_done_nxt;
  logic                lw_stall, br_stall, hazard_stall, mem_miss;

  forwarding_unit u_fwd (
    .rs_d        (rs_d),
    .rt_d        (rt_d),
    .rs_e        (rs_e),
    .rt_e        (rt_e),
    .write_reg_m (write_reg_m),
    .write_reg_w (write_reg_w),
    .reg_write_m (reg_write_m),
    .reg_write_w (reg_write_w),
    .forward_a_d (forward_a_d),
    .forward_b_d (forward_b_d),
    .forward_a_e (forward_a_e),
    .forward_b_e (forward_b_e)
  );

  // Interlocks that only need the decode/execute/memory register fields.
  always_comb begin
    lw_stall = mem_to_reg_e && ((rt_e == rs_d) || (rt_e == rt_d));
    br_stall = branch_d &&
               ((reg_write_e  && ((write_reg_e == rs_d) || (write_reg_e == rt_d))) ||
                (mem_to_reg_m && ((write_reg_m == rs_d) || (write_reg_m == rt_d))));
    hazard_stall = lw_stall || br_stall;
    mem_miss     = dmem_req_m && !dmem_ready;
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state    <= RUN;
      cnt      <= '0;
      mdu_done <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      mdu_done <= mdu_done_nxt;
    end
  end

  // Next state and stall/flush decode; a memory miss overrides everything.
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    mdu_done_nxt = 1'b0;
    stall_f      = 1'b0;
    stall_d      = 1'b0;
    stall_e      = 1'b0;
    stall_m      = 1'b0;
    stall_w      = 1'b0;
    flush_e      = 1'b0;
    flush_m      = 1'b0;

    if (mem_miss) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      stall_e = 1'b1;
      stall_m = 1'b1;
      stall_w = 1'b1;
      if (state != MDU) state_nxt = MEM_WAIT;
    end else if (state == MDU) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      stall_e = 1'b1;
      flush_m = 1'b1;
      if (cnt == CNT_BITS'(1)) begin
        state_nxt    = RUN;
        cnt_nxt      = '0;
        mdu_done_nxt = 1'b1;
      end else begin
        cnt_nxt = cnt - CNT_BITS'(1);
      end
    end else if (mdu_start_e && !mdu_done) begin
      // Issue cycle counts as the first of the N stall cycles.
      stall_f   = 1'b1;
      stall_d   = 1'b1;
      stall_e   = 1'b1;
      flush_m   = 1'b1;
      cnt_nxt   = mdu_load(mdu_div_e);
      state_nxt = MDU;
    end else begin
      stall_f   = hazard_stall;
      stall_d   = hazard_stall;
      flush_e   = hazard_stall;
      state_nxt = RUN;
    end

    flush_d  = pc_src_d && !stall_d;
    mdu_busy = (state == MDU);
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: forwarding, interlocks, mult/div
// sequencing, memory waits and asynchronous clear.
module tb_pipeline_ctrl;

  logic       clk, clr;
  logic [4:0] rs_d, rt_d, rs_e, rt_e, write_reg_e, write_reg_m, write_reg_w;
  logic       reg_write_e, reg_write_m, reg_write_w, mem_to_reg_e, mem_to_reg_m;
  logic       branch_d, pc_src_d, mdu_start_e, mdu_div_e, dmem_req_m, dmem_ready;
  logic       forward_a_d, forward_b_d;
  logic [1:0] forward_a_e, forward_b_e;
  logic       stall_f, stall_d, stall_e, stall_m, stall_w;
  logic       flush_d, flush_e, flush_m, mdu_busy;
  logic [8:0] ctl;

  int checks = 0;
  int errors = 0;

  pipeline_ctrl dut (
    .clk(clk), .clr(clr),
    .rs_d(rs_d), .rt_d(rt_d), .rs_e(rs_e), .rt_e(rt_e),
    .write_reg_e(write_reg_e), .write_reg_m(write_reg_m), .write_reg_w(write_reg_w),
    .reg_write_e(reg_write_e), .reg_write_m(reg_write_m), .reg_write_w(reg_write_w),
    .mem_to_reg_e(mem_to_reg_e), .mem_to_reg_m(mem_to_reg_m),
    .branch_d(branch_d), .pc_src_d(pc_src_d),
    .mdu_start_e(mdu_start_e), .mdu_div_e(mdu_div_e),
    .dmem_req_m(dmem_req_m), .dmem_ready(dmem_ready),
    .forward_a_d(forward_a_d), .forward_b_d(forward_b_d),
    .forward_a_e(forward_a_e), .forward_b_e(forward_b_e),
    .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e),
    .stall_m(stall_m), .stall_w(stall_w),
    .flush_d(flush_d), .flush_e(flush_e), .flush_m(flush_m),
    .mdu_busy(mdu_busy)
  );

  // {stall_f, stall_d, stall_e, stall_m, stall_w, flush_d, flush_e, flush_m, mdu_busy}
  assign ctl = {stall_f, stall_d, stall_e, stall_m, stall_w, flush_d, flush_e, flush_m, mdu_busy};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rs_d = '0; rt_d = '0; rs_e = '0; rt_e = '0;
    write_reg_e = '0; write_reg_m = '0; write_reg_w = '0;
    reg_write_e = 1'b0; reg_write_m = 1'b0; reg_write_w = 1'b0;
    mem_to_reg_e = 1'b0; mem_to_reg_m = 1'b0;
    branch_d = 1'b0; pc_src_d = 1'b0;
    mdu_start_e = 1'b0; mdu_div_e = 1'b0;
    dmem_req_m = 1'b0; dmem_ready = 1'b0;
  endtask

  initial begin
    int stalls, busy, wstalls, end_idx;
    logic [8:0] exp;

    // Reset
    clr = 1'b1;
    idle();
    #1;
    check("reset_ctl", 32'(ctl), 32'h0);
    tick();
    clr = 1'b0;
    #1;
    check("post_reset_ctl", 32'(ctl), 32'h0);

    // Forwarding
    rs_e = 5'd3; write_reg_m = 5'd3; reg_write_m = 1'b1; write_reg_w = 5'd3; reg_write_w = 1'b1;
    #1;
    check("fwd_a_e_m_over_w", 32'(forward_a_e), 32'd2);
    check("fwd_b_e_r0", 32'(forward_b_e), 32'd0);
    rs_e = 5'd0;
    #1;
    check("fwd_a_e_r0", 32'(forward_a_e), 32'd0);
    rt_e = 5'd3; write_reg_m = 5'd4;
    #1;
    check("fwd_b_e_w", 32'(forward_b_e), 32'd1);
    reg_write_w = 1'b0;
    #1;
    check("fwd_b_e_no_we", 32'(forward_b_e), 32'd0);
    rs_d = 5'd7; rt_d = 5'd7; write_reg_m = 5'd7;
    #1;
    check("fwd_a_d", 32'(forward_a_d), 32'd1);
    check("fwd_b_d", 32'(forward_b_d), 32'd1);
    reg_write_m = 1'b0;
    #1;
    check("fwd_d_no_we", 32'({forward_a_d, forward_b_d}), 32'd0);

    // Load-use interlock
    idle();
    tick();
    mem_to_reg_e = 1'b1; rt_e = 5'd5; rs_d = 5'd5;
    #1;
    check("lw_rs", 32'(ctl), 32'b110000100);
    tick();
    rs_d = 5'd1; rt_d = 5'd5;
    #1;
    check("lw_rt", 32'(ctl), 32'b110000100);
    rt_d = 5'd2;
    #1;
    check("lw_none", 32'(ctl), 32'h0);

    // Branch interlock and taken-branch flush
    idle();
    tick();
    branch_d = 1'b1; pc_src_d = 1'b1; rs_d = 5'd1; rt_d = 5'd2;
    reg_write_e = 1'b1; write_reg_e = 5'd8;
    #1;
    check("br_taken_no_hazard", 32'(ctl), 32'b000001000);
    write_reg_e = 5'd2;
    #1;
    check("br_hazard_e", 32'(ctl), 32'b110000100);
    reg_write_e = 1'b0; mem_to_reg_m = 1'b1; write_reg_m = 5'd1;
    #1;
    check("br_hazard_m_load", 32'(ctl), 32'b110000100);

    // Multiply: 4 stall cycles, busy 3, no re-trigger on the done cycle
    idle();
    tick();
    mdu_start_e = 1'b1; pc_src_d = 1'b1;
    stalls = 0; busy = 0;
    for (int i = 0; i < 5; i++) begin
      #1;
      exp = (i == 0) ? 9'b111000010 : (i <= 3) ? 9'b111000011 : 9'b000001000;
      check($sformatf("mult_cyc%0d", i), 32'(ctl), 32'(exp));
      stalls += int'(stall_e);
      busy   += int'(mdu_busy);
      tick();
    end
    mdu_start_e = 1'b0; pc_src_d = 1'b0;
    #1;
    check("mult_after", 32'(ctl), 32'h0);
    check("mult_stall_cycles", 32'(stalls), 32'd4);
    check("mult_busy_cycles", 32'(busy), 32'd3);

    // Divide with a 3-cycle memory miss starting at cycle 5: 35 stall cycles
    idle();
    tick();
    mdu_start_e = 1'b1; mdu_div_e = 1'b1;
    stalls = 0; wstalls = 0; end_idx = -1;
    for (int i = 0; i < 60; i++) begin
      dmem_req_m = (i >= 5) && (i <= 7);
      #1;
      if (i == 5) check("div_miss_ctl", 32'(ctl), 32'b111110001);
      if (i == 8) check("div_resume_ctl", 32'(ctl), 32'b111000011);
      stalls  += int'(stall_e);
      wstalls += int'(stall_w);
      if (!stall_e) begin
        end_idx = i;
        mdu_start_e = 1'b0;
        break;
      end
      tick();
    end
    check("div_end_cycle", 32'(end_idx), 32'd35);
    check("div_stall_cycles", 32'(stalls), 32'd35);
    check("div_stall_w_cycles", 32'(wstalls), 32'd3);
    tick();
    check("div_after", 32'(ctl), 32'h0);

    // Memory wait in RUN, then the ready cycle releases all stalls
    idle();
    dmem_req_m = 1'b1;
    #1;
    check("memwait_enter", 32'(ctl), 32'b111110000);
    tick();
    check("memwait_hold", 32'(ctl), 32'b111110000);
    dmem_ready = 1'b1;
    #1;
    check("memwait_ready", 32'(ctl), 32'h0);
    tick();
    idle();
    #1;
    check("memwait_done", 32'(ctl), 32'h0);

    // Clear mid-divide
    mdu_start_e = 1'b1; mdu_div_e = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    #1;
    check("div_busy_before_clr", 32'(mdu_busy), 32'd1);
    idle();
    clr = 1'b1;
    #1;
    check("clr_mdu_busy", 32'(mdu_busy), 32'd0);
    check("clr_mdu_ctl", 32'(ctl), 32'h0);
    tick();
    clr = 1'b0;
    #1;
    check("clr_mdu_release", 32'(ctl), 32'h0);
    tick();
    check("clr_mdu_next", 32'(ctl), 32'h0);

    // Clear mid memory wait
    dmem_req_m = 1'b1;
    tick();
    check("memwait2_hold", 32'(ctl), 32'b111110000);
    idle();
    clr = 1'b1;
    #1;
    check("clr_memwait_ctl", 32'(ctl), 32'h0);
    tick();
    clr = 1'b0;
    tick();
    check("clr_memwait_release", 32'(ctl), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
